// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, sequential word fetches, and an in-order queue feeding typeDecode.
// Optional FETCH_ILLEGAL_CHECK_EN flags non-32-bit encodings on dec_illegal.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [6:0]  dec_opcode,
  output logic [31:0] dec_pc,
  output logic        dec_illegal
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   pc_r;
  logic [31:0]   instr_q_r [DEPTH];
  logic [31:0]   pc_q_r    [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] discard_r;

  logic          issue_s;
  logic          resp_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic [CW:0]   credit_s;
  logic [CW-1:0] live_s;
  logic [31:0]   resp_pc_s;

  // Credit-based issue plus response/dequeue qualification
  always_comb begin
    credit_s = {1'b0, count_r} + {1'b0, outstanding_r};
    if (rst && !redirect && (credit_s < DEPTH_C)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    resp_s = imem_rvalid && (outstanding_r != {CW{1'b0}});
    drop_s = resp_s && (redirect || (discard_r != {CW{1'b0}}));
    push_s = resp_s && !drop_s;
    pop_s  = (count_r != {CW{1'b0}}) && dec_ready;
    // Fetches since the last redirect are sequential, so the oldest live one sits live_s words behind pc_r
    live_s    = outstanding_r - discard_r;
    resp_pc_s = pc_r - 32'({live_s, 2'b00});
  end

  // PC, in-flight accounting and queue storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r          <= RESET_PC;
      head_r        <= {AW{1'b0}};
      tail_r        <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_q_r[i] <= NOP;
        pc_q_r[i]    <= 32'h0000_0000;
      end
    end else begin
      outstanding_r <= outstanding_r + CW'(issue_s) - CW'(resp_s);
      if (redirect) begin
        pc_r      <= redirect_pc;
        head_r    <= {AW{1'b0}};
        tail_r    <= {AW{1'b0}};
        count_r   <= {CW{1'b0}};
        discard_r <= outstanding_r - CW'(resp_s);
      end else begin
        if (issue_s) begin
          pc_r <= pc_r + 32'd4;
        end
        if (resp_s && (discard_r != {CW{1'b0}})) begin
          discard_r <= discard_r - CW'(1'b1);
        end
        if (push_s) begin
          instr_q_r[tail_r] <= imem_rdata;
          pc_q_r[tail_r]    <= resp_pc_s;
          tail_r            <= tail_r + AW'(1'b1);
        end
        if (pop_s) begin
          head_r <= head_r + AW'(1'b1);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

  // Head presentation; an empty queue shows a NOP at address 0
  always_comb begin
    dec_valid = (count_r != {CW{1'b0}});
    if (dec_valid) begin
      dec_instr = instr_q_r[head_r];
      dec_pc    = pc_q_r[head_r];
    end else begin
      dec_instr = NOP;
      dec_pc    = 32'h0000_0000;
    end
    dec_opcode = dec_instr[6:0];
  end

  assign imem_req  = issue_s;
  assign imem_addr = pc_r;

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign dec_illegal = dec_valid & (dec_instr[1:0] != 2'b11);
`else
  assign dec_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model, directed stimulus
// pushing hand-computed expected {pc, instr} pairs, and a monitor comparing every dequeue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [6:0]  dec_opcode;
  logic [31:0] dec_pc;
  logic        dec_illegal;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] req_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          lat     = 1;
  int          cyc     = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_opcode(dec_opcode),
    .dec_pc(dec_pc), .dec_illegal(dec_illegal)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0000_4501;
    else if (a == 32'h0000_0204) return 32'h0000_0013;
    else return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    dec_ready = 1'b0;
    cycles(3);
    exp_q.delete();
    req_log.delete();
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d entries still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    dec_ready = 1'b0;
  endtask

  // Memory model: in-order responses lat cycles after each sampled request
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      #4;
      if (!rst) begin
        rsp_q.delete();
      end else if (imem_req) begin
        r.due  = cyc + lat;
        r.data = mem_data(imem_addr);
        rsp_q.push_back(r);
        req_log.push_back(imem_addr);
      end
    end
  end

  // Monitor: compares each dequeue against the scoreboard, and idle outputs against NOP
  initial begin
    exp_t e;
    logic exp_ill;
    forever begin
      @(negedge clk);
      #4;
      if (dec_valid) begin
        if (dec_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %h instr %h, required no entry", dec_pc, dec_instr);
          end else begin
            e = exp_q.pop_front();
`ifdef FETCH_ILLEGAL_CHECK_EN
            exp_ill = (e.instr[1:0] != 2'b11);
`else
            exp_ill = 1'b0;
`endif
            check("dec_pc", dec_pc, e.pc);
            check("dec_instr", dec_instr, e.instr);
            check("dec_opcode", {25'h0, dec_opcode}, {25'h0, e.instr[6:0]});
            check("dec_illegal", {31'h0, dec_illegal}, {31'h0, exp_ill});
          end
        end
      end else begin
        check("empty_instr", dec_instr, 32'h0000_0013);
        check("empty_opcode", {25'h0, dec_opcode}, 32'h0000_0013);
        check("empty_pc", dec_pc, 32'h0);
        check("empty_illegal", {31'h0, dec_illegal}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        found;
    logic [31:0] a0, a1, a2;
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = 1'b0;

    // Reset values
    cycles(2);
    #4;
    check("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);

    // Release and stream with latency 1, addr-as-data
    @(negedge clk);
    rst = 1'b1;
    dec_ready = 1'b1;
    lat = 1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4), 32'(i * 4));
    #4;
    check("first_req", {31'h0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    #4;
    check("lat_c1_valid", {31'h0, dec_valid}, 32'h0);
    @(negedge clk);
    #4;
    check("lat_c2_valid", {31'h0, dec_valid}, 32'h1);
    @(negedge clk);
    drain(100, "stream");
    check("req_log_size_ge3", {31'h0, req_log.size() >= 3}, 32'h1);
    a0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF;
    a1 = (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF;
    a2 = (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF;
    check("req_addr0", a0, 32'h0);
    check("req_addr1", a1, 32'h4);
    check("req_addr2", a2, 32'h8);

    // Backpressure: queue fills, requests stop, head holds
    do_reset();
    lat = 1;
    rst = 1'b1;
    cycles(5);
    #4;
    check("bp_req_stall", {31'h0, imem_req}, 32'h0);
    check("bp_valid", {31'h0, dec_valid}, 32'h1);
    check("bp_hold_instr", dec_instr, 32'h0);
    cycles(3);
    #4;
    check("bp_hold_instr_later", dec_instr, 32'h0);
    check("bp_hold_addr", imem_addr, 32'h8);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 32'(i * 4));
    dec_ready = 1'b1;
    drain(100, "backpressure");

    // Redirect with two fetches outstanding at latency 3
    do_reset();
    lat = 3;
    rst = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(i * 4), 32'h100 + 32'(i * 4));
    cycles(2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    #4;
    check("redir_no_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    drain(200, "redirect_outstanding");

    // Redirect coinciding with a response; illegal-check data at 0x200/0x204
    do_reset();
    lat = 2;
    rst = 1'b1;
    dec_ready = 1'b1;
    push_exp(32'h200, 32'h0000_4501);
    push_exp(32'h204, 32'h0000_0013);
    push_exp(32'h208, 32'h0000_0208);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      #1;
      if (imem_rvalid) begin
        found = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    check("rv_coincide_found", {31'h0, found}, 32'h1);
    drain(200, "redirect_rvalid");

    // Redirect with a same-cycle dequeue, to a PC that wraps past the top
    do_reset();
    lat = 1;
    rst = 1'b1;
    cycles(3);
    push_exp(32'h0, 32'h0);
    push_exp(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    push_exp(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    push_exp(32'h0, 32'h0);
    push_exp(32'h4, 32'h4);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    dec_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    drain(100, "wrap");

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
